// File: rtl/lab4_branch_pkg.sv
// Shared types and helpers for the bimodal branch predictor.
// Counter encodings and the PC-to-PHT-index mapping.
package lab4_branch_pkg;

    typedef logic [1:0] pht_ctr_t;

    localparam pht_ctr_t CTR_SNT = 2'b00;
    localparam pht_ctr_t CTR_WNT = 2'b01;
    localparam pht_ctr_t CTR_WT  = 2'b10;
    localparam pht_ctr_t CTR_ST  = 2'b11;

    // Word-aligned PC: drop bits [1:0], keep the low idx_w bits of the word address.
    function automatic logic [31:0] pc2idx(input logic [31:0] pc, input int unsigned idx_w);
        logic [31:0] mask;
        mask = (32'd1 << idx_w) - 32'd1;
        return (pc >> 2) & mask;
    endfunction

endpackage

// File: rtl/lab4_branch_bimodal_pht_dpath_if.sv
// Lookup request/response channel between fetch and the PHT datapath.
interface lab4_branch_bimodal_pht_dpath_if #(
    parameter int unsigned IDX_W = 11
);
    logic             req_val;
    logic             req_rdy;
    logic [31:0]      req_pc;
    logic             resp_val;
    logic             resp_rdy;
    logic             resp_taken;
    logic [IDX_W-1:0] resp_idx;

    modport master (
        output req_val, req_pc, resp_rdy,
        input  req_rdy, resp_val, resp_taken, resp_idx
    );

    modport slave (
        input  req_val, req_pc, resp_rdy,
        output req_rdy, resp_val, resp_taken, resp_idx
    );
endinterface

// File: rtl/lab4_branch_pht_array.sv
// Array of 2-bit saturating counters: two combinational read ports,
// one saturating update port, bulk reset to weakly not-taken.
module lab4_branch_pht_array
    import lab4_branch_pkg::*;
#(
    parameter int unsigned PHT_size = 2048,
    parameter int unsigned IDX_W    = $clog2(PHT_size)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IDX_W-1:0] lookup_idx,
    output pht_ctr_t         lookup_ctr,
    input  logic [IDX_W-1:0] status_idx,
    output pht_ctr_t         status_ctr,
    input  logic [IDX_W-1:0] update_idx,
    input  logic             increment,
    input  logic             decrement
);

    pht_ctr_t ctr [PHT_size];

    assign lookup_ctr = ctr[lookup_idx];
    assign status_ctr = ctr[status_idx];

    // Conflicting strobes leave the entry untouched.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < PHT_size; i++) begin
                ctr[i] <= CTR_WNT;
            end
        end else if (increment && !decrement && ctr[update_idx] != CTR_ST) begin
            ctr[update_idx] <= ctr[update_idx] + 2'd1;
        end else if (decrement && !increment && ctr[update_idx] != CTR_SNT) begin
            ctr[update_idx] <= ctr[update_idx] - 2'd1;
        end
    end

    a_no_dual_strobe: assert property (@(posedge clk) disable iff (reset) !(increment && decrement))
        else $error("increment and decrement asserted together");

endmodule

// File: rtl/lab4_branch_bimodal_pht_dpath.sv
// Bimodal predictor datapath: PHT storage, 1-cycle lookup pipeline with
// a single response register, and saturation status for the control unit.
module lab4_branch_bimodal_pht_dpath
    import lab4_branch_pkg::*;
#(
    parameter  int unsigned PHT_size = 2048,
    localparam int unsigned IDX_W    = $clog2(PHT_size)
) (
    input  logic                                   clk,
    input  logic                                   reset,
    lab4_branch_bimodal_pht_dpath_if.slave         lookup,
    input  logic [IDX_W-1:0]                       update_idx,
    input  logic                                   increment_entry,
    input  logic                                   decrement_entry,
    output logic                                   entry_upper_reached,
    output logic                                   entry_lower_reached
);

    logic [IDX_W-1:0] req_idx;
    pht_ctr_t         lookup_ctr;
    pht_ctr_t         status_ctr;
    logic             req_rdy;
    logic             accept;
    logic             resp_val;
    logic             resp_taken;
    logic [IDX_W-1:0] resp_idx;

    assign req_idx = IDX_W'(pc2idx(lookup.req_pc, IDX_W));

    lab4_branch_pht_array #(
        .PHT_size (PHT_size),
        .IDX_W    (IDX_W)
    ) u_pht (
        .clk        (clk),
        .reset      (reset),
        .lookup_idx (req_idx),
        .lookup_ctr (lookup_ctr),
        .status_idx (update_idx),
        .status_ctr (status_ctr),
        .update_idx (update_idx),
        .increment  (increment_entry),
        .decrement  (decrement_entry)
    );

    assign req_rdy = !resp_val || lookup.resp_rdy;
    assign accept  = lookup.req_val && req_rdy;

    // Sampling the PHT only on accept gives read-before-write against a
    // same-edge update and keeps a held response immune to later updates.
    always_ff @(posedge clk) begin
        if (reset) begin
            resp_val   <= 1'b0;
            resp_taken <= 1'b0;
            resp_idx   <= '0;
        end else if (accept) begin
            resp_val   <= 1'b1;
            resp_taken <= lookup_ctr[1];
            resp_idx   <= req_idx;
        end else if (lookup.resp_rdy) begin
            resp_val   <= 1'b0;
        end
    end

    assign lookup.req_rdy    = req_rdy;
    assign lookup.resp_val   = resp_val;
    assign lookup.resp_taken = resp_taken;
    assign lookup.resp_idx   = resp_idx;

    assign entry_upper_reached = (status_ctr == CTR_ST);
    assign entry_lower_reached = (status_ctr == CTR_SNT);

endmodule

// File: tb/tb_lab4_branch_bimodal_pht_dpath.sv
// Self-checking bench for lab4_branch_bimodal_pht_dpath: scoreboard of expected
// responses built from a behavioural PHT model, plus per-scenario checks.
module tb_lab4_branch_bimodal_pht_dpath;

    localparam int IDX_W = 11;

    typedef struct packed {
        logic             taken;
        logic [IDX_W-1:0] idx;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset;
    logic [IDX_W-1:0] update_idx;
    logic             increment_entry;
    logic             decrement_entry;
    logic             entry_upper_reached;
    logic             entry_lower_reached;

    int   tests_run    = 0;
    int   tests_failed = 0;
    exp_t exp_q[$];
    logic [1:0] mdl_pht [2048];
    logic mdl_live = 1'b0;

    lab4_branch_bimodal_pht_dpath_if #(.IDX_W(IDX_W)) bus ();

    lab4_branch_bimodal_pht_dpath #(.PHT_size(2048)) dut (
        .clk                 (clk),
        .reset               (reset),
        .lookup              (bus),
        .update_idx          (update_idx),
        .increment_entry     (increment_entry),
        .decrement_entry     (decrement_entry),
        .entry_upper_reached (entry_upper_reached),
        .entry_lower_reached (entry_lower_reached)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One clock: scoreboard compare/pop at negedge, model advance at posedge.
    task automatic step();
        logic             exp_rdy;
        logic [IDX_W-1:0] idx;
        exp_t             e;
        @(negedge clk);
        if (mdl_live && !reset) begin
            exp_rdy = (exp_q.size() == 0) || bus.resp_rdy;
            tests_run++;
            if (bus.req_rdy !== exp_rdy) begin
                tests_failed++;
                $display("FAIL sb_req_rdy: got %b expected %b", bus.req_rdy, exp_rdy);
            end
            tests_run++;
            if (entry_upper_reached !== (mdl_pht[update_idx] == 2'b11)) begin
                tests_failed++;
                $display("FAIL sb_upper idx=%h: got %b model ctr %b", update_idx, entry_upper_reached, mdl_pht[update_idx]);
            end
            tests_run++;
            if (entry_lower_reached !== (mdl_pht[update_idx] == 2'b00)) begin
                tests_failed++;
                $display("FAIL sb_lower idx=%h: got %b model ctr %b", update_idx, entry_lower_reached, mdl_pht[update_idx]);
            end
            tests_run++;
            if (exp_q.size() != 0) begin
                if (bus.resp_val !== 1'b1 || bus.resp_taken !== exp_q[0].taken || bus.resp_idx !== exp_q[0].idx) begin
                    tests_failed++;
                    $display("FAIL sb_resp: got val=%b taken=%b idx=%h expected val=1 taken=%b idx=%h",
                             bus.resp_val, bus.resp_taken, bus.resp_idx, exp_q[0].taken, exp_q[0].idx);
                end
                if (bus.resp_rdy) void'(exp_q.pop_front());
            end else if (bus.resp_val !== 1'b0) begin
                tests_failed++;
                $display("FAIL sb_resp_idle: got resp_val=%b expected 0", bus.resp_val);
            end
        end
        @(posedge clk);
        if (reset) begin
            exp_q.delete();
            for (int i = 0; i < 2048; i++) mdl_pht[i] = 2'b01;
            mdl_live = 1'b1;
        end else if (mdl_live) begin
            idx = bus.req_pc[IDX_W+1:2];
            if (bus.req_val && exp_q.size() == 0) begin
                e.taken = mdl_pht[idx][1];
                e.idx   = idx;
                exp_q.push_back(e);
            end
            if (increment_entry && !decrement_entry && mdl_pht[update_idx] != 2'b11)
                mdl_pht[update_idx] = mdl_pht[update_idx] + 2'd1;
            else if (decrement_entry && !increment_entry && mdl_pht[update_idx] != 2'b00)
                mdl_pht[update_idx] = mdl_pht[update_idx] - 2'd1;
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        tests_run++;
        if (bus.resp_val !== 1'b0 || bus.resp_taken !== 1'b0 || bus.resp_idx !== 11'h000) begin
            tests_failed++;
            $display("FAIL reset_resp: got val=%b taken=%b idx=%h expected 0 0 000", bus.resp_val, bus.resp_taken, bus.resp_idx);
        end
        tests_run++;
        if (bus.req_rdy !== 1'b1 || entry_upper_reached !== 1'b0 || entry_lower_reached !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_status: got rdy=%b upper=%b lower=%b expected 1 0 0", bus.req_rdy, entry_upper_reached, entry_lower_reached);
        end
    endtask

    task automatic test_lookup();
        bus.req_val = 1'b1;
        bus.req_pc  = 32'h0000_0200;
        step();
        bus.req_val = 1'b0;
        tests_run++;
        if (bus.resp_val !== 1'b1 || bus.resp_taken !== 1'b0 || bus.resp_idx !== 11'h080) begin
            tests_failed++;
            $display("FAIL lookup_first: got val=%b taken=%b idx=%h expected 1 0 080", bus.resp_val, bus.resp_taken, bus.resp_idx);
        end
        step();
        tests_run++;
        if (bus.resp_val !== 1'b0) begin
            tests_failed++;
            $display("FAIL lookup_drain: got resp_val=%b expected 0", bus.resp_val);
        end
    endtask

    task automatic test_increment_saturate();
        update_idx      = 11'h080;
        increment_entry = 1'b1;
        step();
        tests_run++;
        if (entry_upper_reached !== 1'b0) begin
            tests_failed++;
            $display("FAIL inc_one: got upper=%b expected 0", entry_upper_reached);
        end
        step();
        tests_run++;
        if (entry_upper_reached !== 1'b1 || entry_lower_reached !== 1'b0) begin
            tests_failed++;
            $display("FAIL inc_two: got upper=%b lower=%b expected 1 0", entry_upper_reached, entry_lower_reached);
        end
        step();
        increment_entry = 1'b0;
        tests_run++;
        if (entry_upper_reached !== 1'b1) begin
            tests_failed++;
            $display("FAIL inc_saturate: got upper=%b expected 1", entry_upper_reached);
        end
        bus.req_val = 1'b1;
        bus.req_pc  = 32'h0000_0200;
        step();
        bus.req_val = 1'b0;
        tests_run++;
        if (bus.resp_val !== 1'b1 || bus.resp_taken !== 1'b1 || bus.resp_idx !== 11'h080) begin
            tests_failed++;
            $display("FAIL inc_lookup: got val=%b taken=%b idx=%h expected 1 1 080", bus.resp_val, bus.resp_taken, bus.resp_idx);
        end
        step();
    endtask

    task automatic test_decrement_saturate();
        update_idx      = 11'h003;
        decrement_entry = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            tests_run++;
            if (entry_lower_reached !== 1'b1 || entry_upper_reached !== 1'b0) begin
                tests_failed++;
                $display("FAIL dec_sat_%0d: got lower=%b upper=%b expected 1 0", i, entry_lower_reached, entry_upper_reached);
            end
        end
        decrement_entry = 1'b0;
        bus.req_val = 1'b1;
        bus.req_pc  = 32'h0000_000C;
        step();
        bus.req_val = 1'b0;
        tests_run++;
        if (bus.resp_taken !== 1'b0 || bus.resp_idx !== 11'h003) begin
            tests_failed++;
            $display("FAIL dec_lookup: got taken=%b idx=%h expected 0 003", bus.resp_taken, bus.resp_idx);
        end
        increment_entry = 1'b1;
        step();
        increment_entry = 1'b0;
        tests_run++;
        if (entry_lower_reached !== 1'b0 || entry_upper_reached !== 1'b0) begin
            tests_failed++;
            $display("FAIL dec_no_wrap: got lower=%b upper=%b expected 0 0", entry_lower_reached, entry_upper_reached);
        end
    endtask

    task automatic test_back_to_back();
        bus.resp_rdy = 1'b0;
        bus.req_val  = 1'b1;
        bus.req_pc   = 32'h0000_0004;
        step();
        bus.req_pc   = 32'h0000_0008;
        for (int i = 0; i < 3; i++) begin
            tests_run++;
            if (bus.resp_val !== 1'b1 || bus.resp_idx !== 11'h001 || bus.resp_taken !== 1'b0 || bus.req_rdy !== 1'b0) begin
                tests_failed++;
                $display("FAIL b2b_hold_%0d: got val=%b idx=%h taken=%b rdy=%b expected 1 001 0 0",
                         i, bus.resp_val, bus.resp_idx, bus.resp_taken, bus.req_rdy);
            end
            if (i < 2) step();
        end
        bus.resp_rdy = 1'b1;
        #1;
        tests_run++;
        if (bus.req_rdy !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_release_rdy: got %b expected 1", bus.req_rdy);
        end
        step();
        bus.req_pc = 32'h0000_000C;
        tests_run++;
        if (bus.resp_val !== 1'b1 || bus.resp_idx !== 11'h002) begin
            tests_failed++;
            $display("FAIL b2b_second: got val=%b idx=%h expected 1 002", bus.resp_val, bus.resp_idx);
        end
        step();
        bus.req_val = 1'b0;
        tests_run++;
        if (bus.resp_val !== 1'b1 || bus.resp_idx !== 11'h003) begin
            tests_failed++;
            $display("FAIL b2b_third: got val=%b idx=%h expected 1 003", bus.resp_val, bus.resp_idx);
        end
        step();
        tests_run++;
        if (bus.resp_val !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_drain: got resp_val=%b expected 0", bus.resp_val);
        end
    endtask

    task automatic test_same_cycle_update();
        update_idx      = 11'h005;
        increment_entry = 1'b1;
        bus.req_val     = 1'b1;
        bus.req_pc      = 32'h0000_0014;
        step();
        increment_entry = 1'b0;
        bus.req_val     = 1'b0;
        tests_run++;
        if (bus.resp_taken !== 1'b0 || bus.resp_idx !== 11'h005) begin
            tests_failed++;
            $display("FAIL rbw_old: got taken=%b idx=%h expected 0 005", bus.resp_taken, bus.resp_idx);
        end
        step();
        bus.req_val = 1'b1;
        step();
        bus.req_val = 1'b0;
        tests_run++;
        if (bus.resp_taken !== 1'b1 || bus.resp_idx !== 11'h005) begin
            tests_failed++;
            $display("FAIL rbw_new: got taken=%b idx=%h expected 1 005", bus.resp_taken, bus.resp_idx);
        end
        step();
    endtask

    task automatic test_reset_pending();
        update_idx      = 11'h007;
        increment_entry = 1'b1;
        step();
        step();
        increment_entry = 1'b0;
        tests_run++;
        if (entry_upper_reached !== 1'b1) begin
            tests_failed++;
            $display("FAIL rst_pend_setup: got upper=%b expected 1", entry_upper_reached);
        end
        bus.resp_rdy = 1'b0;
        bus.req_val  = 1'b1;
        bus.req_pc   = 32'h0000_001C;
        step();
        bus.req_val  = 1'b0;
        tests_run++;
        if (bus.resp_val !== 1'b1 || bus.resp_taken !== 1'b1 || bus.resp_idx !== 11'h007) begin
            tests_failed++;
            $display("FAIL rst_pend_held: got val=%b taken=%b idx=%h expected 1 1 007", bus.resp_val, bus.resp_taken, bus.resp_idx);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        tests_run++;
        if (bus.resp_val !== 1'b0 || bus.resp_taken !== 1'b0 || bus.resp_idx !== 11'h000) begin
            tests_failed++;
            $display("FAIL rst_pend_cleared: got val=%b taken=%b idx=%h expected 0 0 000", bus.resp_val, bus.resp_taken, bus.resp_idx);
        end
        tests_run++;
        if (entry_upper_reached !== 1'b0 || entry_lower_reached !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_pend_entry7: got upper=%b lower=%b expected 0 0", entry_upper_reached, entry_lower_reached);
        end
        bus.resp_rdy = 1'b1;
        bus.req_val  = 1'b1;
        step();
        bus.req_pc   = 32'h0000_0200;
        tests_run++;
        if (bus.resp_taken !== 1'b0 || bus.resp_idx !== 11'h007) begin
            tests_failed++;
            $display("FAIL rst_pend_readback7: got taken=%b idx=%h expected 0 007", bus.resp_taken, bus.resp_idx);
        end
        step();
        bus.req_val  = 1'b0;
        tests_run++;
        if (bus.resp_taken !== 1'b0 || bus.resp_idx !== 11'h080) begin
            tests_failed++;
            $display("FAIL rst_pend_readback80: got taken=%b idx=%h expected 0 080", bus.resp_taken, bus.resp_idx);
        end
        step();
    endtask

    task automatic test_pc_bits();
        bus.req_val = 1'b1;
        bus.req_pc  = 32'h0000_0203;
        step();
        bus.req_pc  = 32'hFFFF_F200;
        tests_run++;
        if (bus.resp_idx !== 11'h080) begin
            tests_failed++;
            $display("FAIL pc_low_bits: got idx=%h expected 080", bus.resp_idx);
        end
        step();
        bus.req_val = 1'b0;
        tests_run++;
        if (bus.resp_idx !== 11'h480 || bus.resp_taken !== 1'b0) begin
            tests_failed++;
            $display("FAIL pc_high_bits: got idx=%h taken=%b expected 480 0", bus.resp_idx, bus.resp_taken);
        end
        step();
    endtask

    initial begin
        reset           = 1'b1;
        bus.req_val     = 1'b0;
        bus.req_pc      = '0;
        bus.resp_rdy    = 1'b1;
        update_idx      = '0;
        increment_entry = 1'b0;
        decrement_entry = 1'b0;

        test_reset();
        test_lookup();
        test_increment_saturate();
        test_decrement_saturate();
        test_back_to_back();
        test_same_cycle_update();
        test_reset_pending();
        test_pc_bits();

        step();
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL sb_leftover: got %0d pending responses expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
